// File: rtl/histo_pkg.sv
// histo_pkg
// Shared constants for the histogram serial link (transmit serializer and
// receive side), the receiver byte-FSM state encoding, and the baud divider
// helper.
package histo_pkg;

    localparam int unsigned HISTO_BINS          = 1024;
    localparam int unsigned HISTO_BIN_W         = 10;
    localparam int unsigned HISTO_COUNT_W       = 24;
    localparam int unsigned HISTO_BYTES_PER_BIN = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        longint unsigned den;
        longint unsigned q;
        den = longint'(baud) * longint'(os);
        q   = (longint'(clk_hz) + den / 2) / den;
        return (q == 0) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1 receiver: 2-flop synchronizer, oversample tick divider (restarted on
// start detect) and the IDLE/START/DATA/STOP byte FSM. 16 ticks per bit.
// Ports:
//   clk, reset (sync, active-low), rx (async serial in, idle high)
//   byte_data[7:0]  last received byte, valid with byte_stb
//   byte_stb        1-cycle pulse, stop bit sampled high
//   frame_err_stb   1-cycle pulse, stop bit sampled low (byte dropped)
//   idle            FSM is in IDLE
module uart_rx_byte
    import histo_pkg::*;
#(
    parameter int unsigned DIV = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_stb,
    output logic       frame_err_stb,
    output logic       idle
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             stb_q, stb_d, err_q, err_d;
    rx_state_t        state_q, state_d;
    logic             tick;

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        tick_d  = tick_q;
        bit_d   = bit_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_START;
                    div_d   = '0;
                    tick_d  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    tick_d = tick_q + 4'd1;
                    // 8th tick lands mid start bit; high there means a glitch
                    if (tick_q == 4'd7) begin
                        tick_d = '0;
                        bit_d  = '0;
                        state_d = sync2_q ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        data_d = {sync2_q, data_q[7:1]};
                        bit_d  = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        state_d = RX_IDLE;
                        stb_d   = sync2_q;
                        err_d   = !sync2_q;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    assign byte_data     = data_q;
    assign byte_stb      = stb_q;
    assign frame_err_stb = err_q;
    assign idle          = (state_q == RX_IDLE);

endmodule

// File: rtl/histogram_stream_receiver.sv
// histogram_stream_receiver
// Rebuilds (bin, count) records from the 8N1 histogram link, presents them
// over valid/ready, pulses frame_done with the frame sum, and reports link
// errors (framing / mid-frame timeout) and output overruns.
// Ports:
//   clk, reset (sync, active-low), uart_rx (async serial, idle high)
//   bin_idx/bin_count/bin_valid, bin_ready  record output handshake
//   frame_done  pulse when bin BINS-1 loads into the output register
//   frame_sum   sum of counts of last complete frame
//   frame_err   pulse on framing error or timeout abort
//   overrun     pulse when a word completes while the output reg is stalled
module histogram_stream_receiver
    import histo_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 921_600,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned BINS        = HISTO_BINS,
    parameter int unsigned BIN_W       = HISTO_BIN_W,
    parameter int unsigned COUNT_W     = HISTO_COUNT_W,
    parameter int unsigned TIMEOUT_CYC = 200_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_rx,
    output logic [BIN_W-1:0]         bin_idx,
    output logic [COUNT_W-1:0]       bin_count,
    output logic                     bin_valid,
    input  logic                     bin_ready,
    output logic                     frame_done,
    output logic [COUNT_W+BIN_W-1:0] frame_sum,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SUM_W = COUNT_W + BIN_W;
    localparam int unsigned LO_W  = COUNT_W - 8;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic [7:0] rx_byte;
    logic       rx_stb, rx_err, rx_idle;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx           (uart_rx),
        .byte_data    (rx_byte),
        .byte_stb     (rx_stb),
        .frame_err_stb(rx_err),
        .idle         (rx_idle)
    );

    logic [1:0]         byte_cnt_q;
    logic [LO_W-1:0]    lo_q;
    logic [BIN_W-1:0]   bin_cnt_q;
    logic               pend_q;
    logic [BIN_W-1:0]   pend_idx_q;
    logic [COUNT_W-1:0] pend_count_q;
    logic [SUM_W-1:0]   acc_q, frame_sum_q;
    logic [TO_W-1:0]    to_q;
    logic [BIN_W-1:0]   bin_idx_q;
    logic [COUNT_W-1:0] bin_count_q;
    logic               bin_valid_q, frame_done_q, frame_err_q, overrun_q;

    logic active, timeout_hit, stalled, pend_last;
    logic [SUM_W-1:0] pend_ext;

    assign active      = (byte_cnt_q != '0) || (bin_cnt_q != '0);
    assign timeout_hit = rx_idle && active && (to_q == TO_W'(TIMEOUT_CYC - 1));
    assign stalled     = bin_valid_q && !bin_ready;
    assign pend_last   = (pend_idx_q == BIN_W'(BINS - 1));
    assign pend_ext    = SUM_W'(pend_count_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt_q   <= '0;
            lo_q         <= '0;
            bin_cnt_q    <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            pend_count_q <= '0;
            acc_q        <= '0;
            frame_sum_q  <= '0;
            to_q         <= '0;
            bin_idx_q    <= '0;
            bin_count_q  <= '0;
            bin_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;

            to_q <= (rx_idle && active) ? to_q + TO_W'(1) : '0;

            if (bin_valid_q && bin_ready) bin_valid_q <= 1'b0;

            // Completed word from the previous cycle: load or drop. The
            // accumulator sees every completed word, including dropped ones.
            if (pend_q) begin
                pend_q <= 1'b0;
                if (stalled) begin
                    overrun_q <= 1'b1;
                end else begin
                    bin_valid_q <= 1'b1;
                    bin_idx_q   <= pend_idx_q;
                    bin_count_q <= pend_count_q;
                end
                if (pend_last) begin
                    acc_q <= '0;
                    if (!stalled) begin
                        frame_done_q <= 1'b1;
                        frame_sum_q  <= acc_q + pend_ext;
                    end
                end else begin
                    acc_q <= acc_q + pend_ext;
                end
            end

            // Abort takes priority over the accumulator update above.
            if (rx_err || timeout_hit) begin
                frame_err_q <= 1'b1;
                byte_cnt_q  <= '0;
                bin_cnt_q   <= '0;
                acc_q       <= '0;
                to_q        <= '0;
            end else if (rx_stb) begin
                if (byte_cnt_q == 2'(HISTO_BYTES_PER_BIN - 1)) begin
                    pend_q       <= 1'b1;
                    pend_idx_q   <= bin_cnt_q;
                    pend_count_q <= {rx_byte, lo_q};
                    byte_cnt_q   <= '0;
                    bin_cnt_q    <= (bin_cnt_q == BIN_W'(BINS - 1)) ? '0
                                                                    : bin_cnt_q + BIN_W'(1);
                end else begin
                    // Bytes arrive LSB first; shift in from the top.
                    lo_q       <= {rx_byte, lo_q[LO_W-1:8]};
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                end
            end
        end
    end

    assign bin_idx    = bin_idx_q;
    assign bin_count  = bin_count_q;
    assign bin_valid  = bin_valid_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_histogram_stream_receiver.sv
// Directed bench for histogram_stream_receiver. Scaled configuration:
// 16 bins, one oversample tick per clock (16 clocks per bit), 2000-clock
// timeout, so that a whole frame fits in a short run.
module tb_histogram_stream_receiver;

    localparam int BINS    = 16;
    localparam int BIN_W   = 4;
    localparam int COUNT_W = 24;
    localparam int TO_CYC  = 2000;
    localparam int BITCLK  = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     uart_rx;
    logic [BIN_W-1:0]         bin_idx;
    logic [COUNT_W-1:0]       bin_count;
    logic                     bin_valid;
    logic                     bin_ready;
    logic                     frame_done;
    logic [COUNT_W+BIN_W-1:0] frame_sum;
    logic                     frame_err;
    logic                     overrun;

    histogram_stream_receiver #(
        .CLK_HZ     (16_000_000),
        .BAUD       (1_000_000),
        .OVERSAMPLE (16),
        .BINS       (BINS),
        .BIN_W      (BIN_W),
        .COUNT_W    (COUNT_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .bin_idx   (bin_idx),
        .bin_count (bin_count),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .frame_done(frame_done),
        .frame_sum (frame_sum),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Output monitor: logs accepted records and counts pulses.
    int              n_rec  = 0;
    int              n_done = 0;
    int              n_err  = 0;
    int              n_ovr  = 0;
    int              done_idx = -1;
    logic [BIN_W-1:0]   rec_idx [128];
    logic [COUNT_W-1:0] rec_cnt [128];

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bin_valid === 1'b1 && bin_ready === 1'b1 && n_rec < 128) begin
                rec_idx[n_rec] <= bin_idx;
                rec_cnt[n_rec] <= bin_count;
                n_rec          <= n_rec + 1;
            end
            if (frame_done === 1'b1) begin
                n_done   <= n_done + 1;
                done_idx <= int'(bin_idx);
            end
            if (frame_err === 1'b1) n_err <= n_err + 1;
            if (overrun === 1'b1)   n_ovr <= n_ovr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (BITCLK) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, stop bit, then one idle bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        send_bit(1'b1);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[23:16], 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        settle();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base, d0, e0, o0, cyc;

    initial begin
        reset     = 1'b0;
        uart_rx   = 1'b1;
        bin_ready = 1'b0;

        // Reset held with the line toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            uart_rx = ~uart_rx;
        end
        #1;
        check("rst_valid", bin_valid, 0);
        check("rst_idx", bin_idx, 0);
        check("rst_count", bin_count, 0);
        check("rst_sum", frame_sum, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        check("rst_ovr", overrun, 0);
        uart_rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("post_rst_err", n_err, 0);
        check("post_rst_rec", n_rec, 0);
        check("post_rst_valid", bin_valid, 0);

        // Nominal frame, count[i] = 3*i, ready always high.
        bin_ready = 1'b1;
        base = n_rec; d0 = n_done; e0 = n_err; o0 = n_ovr;
        for (int i = 0; i < BINS; i++) send_word(24'(i * 3));
        settle();
        check("nom_nrec", n_rec - base, BINS);
        for (int i = 0; i < BINS; i++) begin
            check($sformatf("nom_idx%0d", i), rec_idx[base + i], i);
            check($sformatf("nom_cnt%0d", i), rec_cnt[base + i], i * 3);
        end
        check("nom_done_n", n_done - d0, 1);
        check("nom_done_idx", done_idx, BINS - 1);
        check("nom_sum", frame_sum, 360);
        check("nom_err", n_err - e0, 0);
        check("nom_ovr", n_ovr - o0, 0);

        // Byte order: bytes C7, B6, A5 form 0xA5B6C7 at bin 0.
        base = n_rec;
        send_word(24'hA5B6C7);
        settle();
        check("bo_nrec", n_rec - base, 1);
        check("bo_idx", rec_idx[base], 0);
        check("bo_cnt", rec_cnt[base], 24'hA5B6C7);
        check("bo_sum_hold", frame_sum, 360);

        do_reset();
        check("rst2_sum", frame_sum, 0);

        // Backpressure across two words.
        bin_ready = 1'b0;
        o0 = n_ovr;
        send_word(24'h000111);
        check("bp_valid1", bin_valid, 1);
        check("bp_idx1", bin_idx, 0);
        check("bp_cnt1", bin_count, 24'h000111);
        send_word(24'h000222);
        check("bp_valid2", bin_valid, 1);
        check("bp_idx_hold", bin_idx, 0);
        check("bp_cnt_hold", bin_count, 24'h000111);
        check("bp_ovr", n_ovr - o0, 1);
        base = n_rec;
        bin_ready = 1'b1;
        settle();
        check("bp_drain_n", n_rec - base, 1);
        check("bp_drain_idx", rec_idx[base], 0);
        check("bp_drain_valid", bin_valid, 0);
        send_word(24'h000333);
        settle();
        check("bp_next_n", n_rec - base, 2);
        check("bp_next_idx", rec_idx[base + 1], 2);
        check("bp_next_cnt", rec_cnt[base + 1], 24'h000333);

        do_reset();

        // Framing error on byte 1 of bin 5.
        base = n_rec; d0 = n_done; e0 = n_err;
        for (int i = 0; i < 5; i++) send_word(24'(i + 100));
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_bit(1'b1);
        settle();
        check("fe_err", n_err - e0, 1);
        check("fe_nrec", n_rec - base, 5);
        send_word(24'h0ABCDE);
        settle();
        check("fe_next_idx", rec_idx[base + 5], 0);
        check("fe_next_cnt", rec_cnt[base + 5], 24'h0ABCDE);
        check("fe_no_done", n_done - d0, 0);
        check("fe_err_once", n_err - e0, 1);

        do_reset();

        // Timeout: stream stops after bin 10.
        e0 = n_err;
        for (int i = 0; i <= 10; i++) send_word(24'(i + 1));
        cyc = 0;
        while (frame_err !== 1'b1 && cyc < TO_CYC + 500) begin
            @(negedge clk);
            cyc++;
        end
        check("to_seen", frame_err, 1);
        check("to_window", (cyc >= TO_CYC - 30) && (cyc <= TO_CYC - 10), 1);
        settle();
        check("to_err_once", n_err - e0, 1);
        base = n_rec;
        send_word(24'h000555);
        settle();
        check("to_next_idx", rec_idx[base], 0);
        check("to_next_cnt", rec_cnt[base], 24'h000555);

        // 3-clock low glitch while idle: no byte, no error.
        base = n_rec; e0 = n_err;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("gl_err", n_err - e0, 0);
        check("gl_rec", n_rec - base, 0);
        send_word(24'h000777);
        settle();
        check("gl_next_idx", rec_idx[base], 1);
        check("gl_next_cnt", rec_cnt[base], 24'h000777);
        check("gl_err_after", n_err - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
